sdiv_iter: RTL
==============

// Module: sdiv_iter
// PURPOSE
//  Sequential signed integer divider, the inverse of the mult4x4 Baugh-Wooley multiplier.
//  Produces Quotient = Dividend / Divisor, truncated toward zero, and Remainder with the sign of the Dividend.
//  Uses iterative restoring division on magnitudes, then applies a sign fixup.
//  Sits beside mult4x4 in the arithmetic library. Start/Done handshake, one operation in flight.
// PARAMETERS
//  WIDTH  4  operand/result width in bits, two's complement; legal range 2..32
// PORTS
//  Clk        in   1      rising-edge clock; the only clock
//  Reset      in   1      asynchronous, active-high reset
//  Start      in   1      request; sampled only when Busy=0
//  InA        in   WIDTH  signed dividend, captured on the accepting edge
//  InB        in   WIDTH  signed divisor, captured on the accepting edge
//  Busy       out  1      high in CALC and FIX
//  Done       out  1      one-cycle pulse; results are valid from this cycle on
//  Quotient   out  WIDTH  signed quotient, held until the next Done
//  Remainder  out  WIDTH  signed remainder, held until the next Done
//  Overflow   out  1      only when SDIV_OVF_FLAG_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; Busy, Done, Quotient, Remainder and Overflow = 0.
//    A division in progress is discarded. The first edge after Reset deasserts may accept Start.
//  States: IDLE, CALC, FIX, DONE.
//  IDLE/DONE --Start--> CALC.
//    Latch |InA| and |InB| at WIDTH+1 bits, so that -2^(WIDTH-1) is representable.
//    Latch the sign bits. Step counter = WIDTH-1. Partial remainder = 0.
//  CALC: one restoring step per edge.
//    Shift the MSB of the dividend magnitude into the remainder.
//    Trial-subtract the divisor magnitude. The quotient bit is 1 if the result is >= 0; otherwise restore.
//    Leave to FIX on the edge where counter == 0, after exactly WIDTH steps.
//  FIX: negate the quotient if the operand signs differ. Negate the remainder if InA < 0.
//    Register Quotient and Remainder, truncated to WIDTH bits. Next state is DONE.
//  DONE: Done=1 for exactly one cycle, then IDLE.
//    Start in DONE is accepted (back-to-back operation).
//  Latency: Start accepted at edge T0 gives Done high in the cycle after edge T(WIDTH+1).
//    Issue interval is WIDTH+2 cycles.
//    Latency is fixed; there is no early termination, including for the special cases below.
//  Start while Busy=1 is ignored. InA and InB are don't-care except on the accepting edge.
//  Divide by zero (InB=0): Quotient = all ones (-1), Remainder = InA.
//    The restoring datapath produces this naturally; FIX must bypass sign correction for B=0.
//  Signed overflow (InA = -2^(WIDTH-1), InB = -1): Quotient = -2^(WIDTH-1) (wraps), Remainder = 0.
//  Quotient and Remainder change only on the FIX->DONE edge; they are stable in IDLE and CALC.
//  Invariant when InB != 0: Quotient*InB + Remainder == InA (mod 2^WIDTH), and |Remainder| < |InB|.
// CONFIGURATION
//  SDIV_OVF_FLAG_EN defined:
//    Adds the Overflow output, registered with the results.
//    Overflow=1 for divide by zero or MIN/-1, and 0 otherwise.
//    It is held until the next Done, and cleared by Reset.
//  SDIV_OVF_FLAG_EN undefined:
//    The Overflow port and its logic are absent. Quotient and Remainder values are unchanged.
// STRUCTURE
//  Package sdiv_pkg:
//    state_t enum {IDLE, CALC, FIX, DONE};
//    function mag(value, width) returning the WIDTH+1-bit absolute value;
//    localparam CNT_W = $clog2(WIDTH).
//  Sub-module sdiv_step: a combinational single restoring step. It takes the partial remainder,
//    the next dividend bit and the divisor magnitude, and returns the new remainder and the
//    quotient bit. Instantiate it once inside sdiv_iter.
// TESTING  (WIDTH=4 unless stated)
//  1. InA=7, InB=2 -> Quotient=3, Remainder=1; Done exactly 5 cycles after acceptance; Busy high for 5 cycles.
//  2. Sign cases:
//     -7/2 -> Q=-3, R=-1;  7/-2 -> Q=-3, R=1;  -7/-2 -> Q=3, R=-1.
//  3. -8/-1 -> Q=-8, R=0, Overflow=1 (if enabled).
//     5/0 -> Q=-1, R=5, Overflow=1.
//     0/0 -> Q=-1, R=0.
//  4. Exhaustive 256 pairs, back-to-back with Start held high.
//     Compare against $signed / and % for InB != 0, and the rules above for InB=0.
//     The issue interval must be 6 cycles.
//  5. Pulse Start with new operands at mid-CALC -> ignored; results belong to the first operation.
//  6. Assert Reset at mid-CALC -> all outputs 0 immediately, with no clock needed.
//     No Done follows. The next Start completes correctly.
//     Repeat the exhaustive check at WIDTH=8 on random samples.

Source files
------------

// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Counter width is sized for the widest legal operand (32 bits).
package sdiv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int MAX_WIDTH = 32;
  localparam int CNT_W     = $clog2(MAX_WIDTH);

  // Absolute value of a width-bit two's complement number held in the low bits of value.
  // The result is one bit wider so that -2^(width-1) has a representable magnitude.
  function automatic logic [MAX_WIDTH:0] mag(input logic [MAX_WIDTH-1:0] value, input int width);
    logic [MAX_WIDTH:0] v;
    v = {1'b0, value};
    if (value[width-1]) begin
      v = v | ({(MAX_WIDTH+1){1'b1}} << width);
      v = -v;
    end
    return v;
  endfunction

endpackage

// File: rtl/sdiv_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module sdiv_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH:0]   i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The restored remainder never exceeds the divisor magnitude, so WIDTH bits hold it.
  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= i_dvs);
  assign w_diff  = WIDTH'(w_shift - i_dvs);
  assign o_rem   = o_q ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/sdiv_iter.sv
// Iterative signed divider: restoring division on magnitudes followed by a sign fixup.
// Optional Overflow output is enabled by defining SDIV_OVF_FLAG_EN.
module sdiv_iter
  import sdiv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
`ifdef SDIV_OVF_FLAG_EN
  ,
  output logic             Overflow
`endif
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_mag;
  logic [WIDTH:0]   r_b_mag;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_sa;
  logic             r_sb;

  logic [WIDTH-1:0] w_rem;
  logic             w_q;
  logic             w_b_zero;

  sdiv_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_a_mag[WIDTH-1]),
    .i_dvs (r_b_mag),
    .o_rem (w_rem),
    .o_q   (w_q)
  );

  assign w_b_zero = ~|r_b_mag;

`ifdef SDIV_OVF_FLAG_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  logic r_ovf_pend;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ovf_pend <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      if ((r_state == IDLE || r_state == DONE) && Start)
        r_ovf_pend <= (InB == '0) || (InA == MIN_VAL && InB == '1);
      if (r_state == FIX)
        Overflow <= r_ovf_pend;
    end
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (Start) begin
            // |InA| <= 2^(WIDTH-1) always fits WIDTH unsigned bits; the divisor keeps the extra bit for the compare.
            r_a_mag <= WIDTH'(mag(MAX_WIDTH'(InA), WIDTH));
            r_b_mag <= (WIDTH+1)'(mag(MAX_WIDTH'(InB), WIDTH));
            r_sa    <= InA[WIDTH-1];
            r_sb    <= InB[WIDTH-1];
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= CNT_W'(WIDTH-1);
            Busy    <= 1'b1;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_rem   <= w_rem;
          r_quo   <= {r_quo[WIDTH-2:0], w_q};
          r_a_mag <= {r_a_mag[WIDTH-2:0], 1'b0};
          if (r_cnt == '0)
            r_state <= FIX;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          // Divide by zero leaves the all-ones quotient untouched; the remainder still takes the dividend's sign.
          Quotient  <= ((r_sa ^ r_sb) && !w_b_zero) ? -r_quo : r_quo;
          Remainder <= r_sa ? -r_rem : r_rem;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          r_state   <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
